// File: rtl/sdram_burst_sched.sv
// Burst scheduler for the SDRAM-as-FIFO path: arbitrates write/read bursts onto the
// single SDRAM controller port and owns the ring-buffer pointers and occupancy count.
module sdram_burst_sched #(
    parameter int unsigned       ADDR_W        = 24,
    parameter logic [ADDR_W-1:0] RING_BASE     = 24'd0,
    parameter logic [ADDR_W-1:0] RING_SIZE     = 24'd1024,
    parameter logic [15:0]       RD_FIFO_DEPTH = 16'd1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_end,
    input  logic              read_valid,
    input  logic              wr_rst,
    input  logic              rd_rst,
    input  logic [8:0]        wr_burst_len,
    input  logic [8:0]        rd_burst_len,
    input  logic [15:0]       wr_fifo_num,
    input  logic [15:0]       rd_fifo_num,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic              sdram_wr_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [8:0]        sdram_wr_burst,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic [8:0]        sdram_rd_burst,
    output logic              busy,
    output logic [ADDR_W:0]   sdram_used
);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_e;

    localparam logic [ADDR_W:0] RING_END = {1'b0, RING_BASE} + {1'b0, RING_SIZE};

    state_e            state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [8:0]        wr_burst_q, wr_burst_d;
    logic [8:0]        rd_burst_q, rd_burst_d;
    logic [8:0]        beat_q, beat_d;
    logic [ADDR_W:0]   used_q, used_d;
    logic              wr_rst_pend_q, wr_rst_pend_d;
    logic              rd_rst_pend_q, rd_rst_pend_d;

    logic [ADDR_W+1:0] used_after_wr;
    logic [16:0]       rd_fifo_after;
    logic              wr_elig, rd_elig;

    // Pointer wraps to the ring base whenever the next burst would start at or past the end.
    function automatic logic [ADDR_W-1:0] ring_advance(input logic [ADDR_W-1:0] ptr,
                                                       input logic [8:0]        len);
        logic [ADDR_W:0] nxt;
        nxt = {1'b0, ptr} + {{(ADDR_W-8){1'b0}}, len};
        if (nxt >= RING_END) ring_advance = RING_BASE;
        else                 ring_advance = nxt[ADDR_W-1:0];
    endfunction

    assign used_after_wr = {1'b0, used_q} + {{(ADDR_W-7){1'b0}}, wr_burst_len};
    assign rd_fifo_after = {1'b0, rd_fifo_num} + {8'd0, rd_burst_len};

    assign wr_elig = init_end && (wr_burst_len != 9'd0)
                  && (wr_fifo_num >= {7'd0, wr_burst_len})
                  && (used_after_wr <= {2'b00, RING_SIZE});

    assign rd_elig = init_end && read_valid && (rd_burst_len != 9'd0)
                  && (used_q >= {{(ADDR_W-8){1'b0}}, rd_burst_len})
                  && (rd_fifo_after <= {1'b0, RD_FIFO_DEPTH});

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block infers a latch.
        state_d       = state_q;
        last_wr_d     = last_wr_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        wr_burst_d    = wr_burst_q;
        rd_burst_d    = rd_burst_q;
        beat_d        = beat_q;
        used_d        = used_q;
        wr_rst_pend_d = wr_rst_pend_q;
        rd_rst_pend_d = rd_rst_pend_q;

        if (state_q != ST_IDLE) begin
            wr_rst_pend_d = wr_rst_pend_q | wr_rst;
            rd_rst_pend_d = rd_rst_pend_q | rd_rst;
        end

        case (state_q)
            ST_IDLE: begin
                // A ring reset consumes the whole IDLE cycle; arbitration resumes next cycle.
                if (wr_rst || wr_rst_pend_q) begin
                    wr_addr_d     = RING_BASE;
                    rd_addr_d     = RING_BASE;
                    used_d        = '0;
                    wr_rst_pend_d = 1'b0;
                    rd_rst_pend_d = 1'b0;
                end else if (rd_rst || rd_rst_pend_q) begin
                    rd_addr_d     = wr_addr_q;
                    used_d        = '0;
                    rd_rst_pend_d = 1'b0;
                end else if (wr_elig && (!rd_elig || !last_wr_q)) begin
                    state_d    = ST_WRITE;
                    wr_burst_d = wr_burst_len;
                    last_wr_d  = 1'b1;
                end else if (rd_elig) begin
                    state_d    = ST_READ;
                    rd_burst_d = rd_burst_len;
                    last_wr_d  = 1'b0;
                end
            end
            ST_WRITE: begin
                if (sdram_wr_ack) begin
                    if (beat_q == wr_burst_q - 9'd1) begin
                        state_d   = ST_IDLE;
                        beat_d    = '0;
                        wr_addr_d = ring_advance(wr_addr_q, wr_burst_q);
                        used_d    = used_q + {{(ADDR_W-8){1'b0}}, wr_burst_q};
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            ST_READ: begin
                if (sdram_rd_ack) begin
                    if (beat_q == rd_burst_q - 9'd1) begin
                        state_d   = ST_IDLE;
                        beat_d    = '0;
                        rd_addr_d = ring_advance(rd_addr_q, rd_burst_q);
                        used_d    = used_q - {{(ADDR_W-8){1'b0}}, rd_burst_q};
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            last_wr_q     <= 1'b0;
            wr_addr_q     <= RING_BASE;
            rd_addr_q     <= RING_BASE;
            wr_burst_q    <= '0;
            rd_burst_q    <= '0;
            beat_q        <= '0;
            used_q        <= '0;
            wr_rst_pend_q <= 1'b0;
            rd_rst_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_wr_q     <= last_wr_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            wr_burst_q    <= wr_burst_d;
            rd_burst_q    <= rd_burst_d;
            beat_q        <= beat_d;
            used_q        <= used_d;
            wr_rst_pend_q <= wr_rst_pend_d;
            rd_rst_pend_q <= rd_rst_pend_d;
        end
    end

    assign sdram_wr_req   = (state_q == ST_WRITE);
    assign sdram_rd_req   = (state_q == ST_READ);
    assign busy           = (state_q != ST_IDLE);
    assign sdram_wr_addr  = wr_addr_q;
    assign sdram_rd_addr  = rd_addr_q;
    assign sdram_wr_burst = wr_burst_q;
    assign sdram_rd_burst = rd_burst_q;
    assign sdram_used     = used_q;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Self-checking bench for sdram_burst_sched: eligibility table, directed burst sequences,
// then random stimulus compared against a ring-buffer reference model.
module tb_sdram_burst_sched;

    localparam int ADDR_W    = 24;
    localparam int BASE      = 0;
    localparam int RING_SIZE = 1024;
    localparam int RD_DEPTH  = 1024;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              init_end, read_valid, wr_rst, rd_rst;
    logic [8:0]        wr_burst_len, rd_burst_len;
    logic [15:0]       wr_fifo_num, rd_fifo_num;
    logic              sdram_wr_ack, sdram_rd_ack;
    logic              sdram_wr_req, sdram_rd_req, busy;
    logic [ADDR_W-1:0] sdram_wr_addr, sdram_rd_addr;
    logic [8:0]        sdram_wr_burst, sdram_rd_burst;
    logic [ADDR_W:0]   sdram_used;

    int n_checks = 0;
    int n_errors = 0;

    sdram_burst_sched dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .init_end      (init_end),
        .read_valid    (read_valid),
        .wr_rst        (wr_rst),
        .rd_rst        (rd_rst),
        .wr_burst_len  (wr_burst_len),
        .rd_burst_len  (rd_burst_len),
        .wr_fifo_num   (wr_fifo_num),
        .rd_fifo_num   (rd_fifo_num),
        .sdram_wr_ack  (sdram_wr_ack),
        .sdram_rd_ack  (sdram_rd_ack),
        .sdram_wr_req  (sdram_wr_req),
        .sdram_wr_addr (sdram_wr_addr),
        .sdram_wr_burst(sdram_wr_burst),
        .sdram_rd_req  (sdram_rd_req),
        .sdram_rd_addr (sdram_rd_addr),
        .sdram_rd_burst(sdram_rd_burst),
        .busy          (busy),
        .sdram_used    (sdram_used)
    );

    always #10 sys_clk = ~sys_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: ring state as plain integers, bursts tracked by beats still owed.
    int m_mode;       // 0 idle, 1 write burst, 2 read burst
    int m_left;
    int m_wptr, m_rptr, m_used, m_wlen, m_rlen;
    bit m_prefer_wr, m_wrst_p, m_rrst_p;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0;
        m_wptr = BASE; m_rptr = BASE; m_used = 0;
        m_wlen = 0; m_rlen = 0;
        m_prefer_wr = 1'b1; m_wrst_p = 1'b0; m_rrst_p = 1'b0;
    endtask

    function automatic int ring_next(input int p, input int len);
        return (p + len >= BASE + RING_SIZE) ? BASE : p + len;
    endfunction

    // Predict the state after the coming clock edge from the inputs now applied.
    task automatic model_edge();
        bit we, re;
        if (m_mode == 0) begin
            if (wr_rst || m_wrst_p) begin
                m_wptr = BASE; m_rptr = BASE; m_used = 0;
                m_wrst_p = 1'b0; m_rrst_p = 1'b0;
            end else if (rd_rst || m_rrst_p) begin
                m_rptr = m_wptr; m_used = 0; m_rrst_p = 1'b0;
            end else begin
                we = init_end && (int'(wr_burst_len) != 0)
                     && (int'(wr_fifo_num) >= int'(wr_burst_len))
                     && (m_used + int'(wr_burst_len) <= RING_SIZE);
                re = init_end && read_valid && (int'(rd_burst_len) != 0)
                     && (m_used >= int'(rd_burst_len))
                     && (int'(rd_fifo_num) + int'(rd_burst_len) <= RD_DEPTH);
                if (we && (!re || m_prefer_wr)) begin
                    m_mode = 1; m_wlen = int'(wr_burst_len); m_left = m_wlen; m_prefer_wr = 1'b0;
                end else if (re) begin
                    m_mode = 2; m_rlen = int'(rd_burst_len); m_left = m_rlen; m_prefer_wr = 1'b1;
                end
            end
        end else begin
            if (wr_rst) m_wrst_p = 1'b1;
            if (rd_rst) m_rrst_p = 1'b1;
            if (m_mode == 1 && sdram_wr_ack) begin
                m_left--;
                if (m_left == 0) begin
                    m_used += m_wlen; m_wptr = ring_next(m_wptr, m_wlen); m_mode = 0;
                end
            end else if (m_mode == 2 && sdram_rd_ack) begin
                m_left--;
                if (m_left == 0) begin
                    m_used -= m_rlen; m_rptr = ring_next(m_rptr, m_rlen); m_mode = 0;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        init_end = 0; read_valid = 0; wr_rst = 0; rd_rst = 0;
        wr_burst_len = 0; rd_burst_len = 0; wr_fifo_num = 0; rd_fifo_num = 0;
        sdram_wr_ack = 0; sdram_rd_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        sys_rst_n = 0;
        step();
        step();
        sys_rst_n = 1;
        model_reset();
    endtask

    task automatic expect_state(input string tag, input bit wreq, input bit rreq,
                                input int waddr, input int raddr, input int used);
        check({tag, ".wr_req"},  sdram_wr_req,  wreq);
        check({tag, ".rd_req"},  sdram_rd_req,  rreq);
        check({tag, ".busy"},    busy,          wreq | rreq);
        check({tag, ".wr_addr"}, sdram_wr_addr, waddr);
        check({tag, ".rd_addr"}, sdram_rd_addr, raddr);
        check({tag, ".used"},    sdram_used,    used);
    endtask

    // Confirms the idle gap, lets one edge pass, then checks the granted burst.
    task automatic grant(input string tag, input bit is_wr, input int addr, input int len);
        check({tag, ".gap"}, {sdram_wr_req, sdram_rd_req}, 0);
        step();
        check({tag, ".req"},  {sdram_wr_req, sdram_rd_req}, is_wr ? 2'b10 : 2'b01);
        check({tag, ".addr"}, is_wr ? sdram_wr_addr : sdram_rd_addr, addr);
        check({tag, ".len"},  is_wr ? sdram_wr_burst : sdram_rd_burst, len);
    endtask

    task automatic burst(input bit is_wr, input int n);
        for (int i = 0; i < n; i++) begin
            sdram_wr_ack = is_wr;
            sdram_rd_ack = !is_wr;
            step();
        end
        sdram_wr_ack = 0;
        sdram_rd_ack = 0;
    endtask

    function automatic logic [8:0] pick_len();
        if ($urandom_range(0, 19) == 0) return 9'd0;
        return 9'(1 << $urandom_range(0, 8));
    endfunction

    typedef struct {
        logic       ie, rv;
        logic [8:0] wl, rl;
        logic [15:0] wf, rf;
        logic       exp_w, exp_r;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 9'd10,  9'd0, 16'd10,  16'd0, 1'b0, 1'b0}; // init_end low
        vecs[1] = '{1'b1, 1'b0, 9'd0,   9'd0, 16'd10,  16'd0, 1'b0, 1'b0}; // zero length
        vecs[2] = '{1'b1, 1'b0, 9'd10,  9'd0, 16'd9,   16'd0, 1'b0, 1'b0}; // fifo one short
        vecs[3] = '{1'b1, 1'b0, 9'd10,  9'd0, 16'd10,  16'd0, 1'b1, 1'b0}; // exact fill
        vecs[4] = '{1'b1, 1'b0, 9'd256, 9'd0, 16'd255, 16'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 9'd256, 9'd0, 16'd256, 16'd0, 1'b1, 1'b0}; // max length
        vecs[6] = '{1'b1, 1'b1, 9'd0,   9'd1, 16'd0,   16'd0, 1'b0, 1'b0}; // empty ring, no read
        vecs[7] = '{1'b1, 1'b1, 9'd1,   9'd1, 16'd1,   16'd0, 1'b1, 1'b0};

        // Reset values
        do_reset();
        expect_state("reset", 0, 0, 0, 0, 0);
        check("reset.wr_burst", sdram_wr_burst, 0);
        check("reset.rd_burst", sdram_rd_burst, 0);

        // Eligibility table from the empty ring
        for (int i = 0; i < 8; i++) begin
            do_reset();
            init_end = vecs[i].ie; read_valid = vecs[i].rv;
            wr_burst_len = vecs[i].wl; rd_burst_len = vecs[i].rl;
            wr_fifo_num = vecs[i].wf; rd_fifo_num = vecs[i].rf;
            step();
            check($sformatf("vec%0d.req", i), {sdram_wr_req, sdram_rd_req}, {vecs[i].exp_w, vecs[i].exp_r});
            check($sformatf("vec%0d.wr_burst", i), sdram_wr_burst, vecs[i].exp_w ? vecs[i].wl : 9'd0);
        end

        // Write then read
        do_reset();
        init_end = 1; wr_burst_len = 10; rd_burst_len = 10; wr_fifo_num = 10;
        grant("t1.w", 1, 0, 10);
        wr_fifo_num = 0;
        burst(1, 10);
        expect_state("t1.wdone", 0, 0, 10, 0, 10);
        read_valid = 1;
        grant("t1.r", 0, 0, 10);
        burst(0, 10);
        expect_state("t1.rdone", 0, 0, 10, 10, 0);

        // Round-robin on persistent tie
        do_reset();
        init_end = 1; wr_burst_len = 10; rd_burst_len = 10; wr_fifo_num = 10;
        for (int k = 0; k < 3; k++) begin
            grant($sformatf("t2.pre%0d", k), 1, k * 10, 10);
            burst(1, 10);
        end
        wr_fifo_num = 0; read_valid = 1;
        grant("t2.pre_r", 0, 0, 10);
        wr_fifo_num = 10;
        burst(0, 10);
        check("t2.used20", sdram_used, 20);
        for (int k = 0; k < 2; k++) begin
            grant($sformatf("t2.w%0d", k), 1, 30 + k * 10, 10);
            burst(1, 10);
            grant($sformatf("t2.r%0d", k), 0, 10 + k * 10, 10);
            burst(0, 10);
        end
        check("t2.used_end", sdram_used, 20);

        // Ring wrap-around and full-ring blocking
        do_reset();
        init_end = 1; wr_burst_len = 256; rd_burst_len = 256; wr_fifo_num = 256;
        for (int k = 0; k < 4; k++) begin
            grant($sformatf("t3.w%0d", k), 1, k * 256, 256);
            burst(1, 256);
        end
        expect_state("t3.full", 0, 0, 0, 0, 1024);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t3.blocked%0d", k), sdram_wr_req, 0);
        end
        read_valid = 1;
        grant("t3.r", 0, 0, 256);
        burst(0, 256);
        check("t3.used768", sdram_used, 768);
        grant("t3.w_after", 1, 0, 256);
        burst(1, 256);
        expect_state("t3.end", 0, 0, 256, 256, 1024);

        // Read FIFO backpressure boundary
        do_reset();
        init_end = 1; wr_burst_len = 100; wr_fifo_num = 100;
        grant("t4.w", 1, 0, 100);
        wr_fifo_num = 0;
        burst(1, 100);
        rd_burst_len = 10; read_valid = 1; rd_fifo_num = 1020;
        step();
        check("t4.bp1020", sdram_rd_req, 0);
        rd_fifo_num = 1015;
        step();
        check("t4.bp1015", sdram_rd_req, 0);
        rd_fifo_num = 1014;
        grant("t4.r", 0, 0, 10);
        burst(0, 10);
        check("t4.used90", sdram_used, 90);

        // wr_rst mid-burst is deferred to the next IDLE cycle; rd_rst in IDLE
        do_reset();
        init_end = 1; wr_burst_len = 10; wr_fifo_num = 10;
        grant("t5.w0", 1, 0, 10);
        burst(1, 10);
        grant("t5.w1", 1, 10, 10);
        burst(1, 3);
        wr_rst = 1; sdram_wr_ack = 1;
        step();
        wr_rst = 0;
        burst(1, 6);
        expect_state("t5.end", 0, 0, 20, 0, 20);
        step();
        expect_state("t5.cleared", 0, 0, 0, 0, 0);
        grant("t5.w2", 1, 0, 10);
        wr_fifo_num = 0;
        burst(1, 10);
        rd_rst = 1;
        step();
        rd_rst = 0;
        expect_state("t5.rd_rst", 0, 0, 10, 10, 0);

        // Async reset mid-burst
        do_reset();
        init_end = 1; wr_burst_len = 10; wr_fifo_num = 10;
        grant("t6.w0", 1, 0, 10);
        burst(1, 10);
        grant("t6.w1", 1, 10, 10);
        burst(1, 5);
        sys_rst_n = 0;
        #1;
        expect_state("t6.arst", 0, 0, 0, 0, 0);
        check("t6.arst.wr_burst", sdram_wr_burst, 0);
        init_end = 0; sdram_wr_ack = 1;
        step();
        sys_rst_n = 1;
        step();
        step();
        sdram_wr_ack = 0;
        expect_state("t6.after", 0, 0, 0, 0, 0);

        // Random stimulus against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            init_end     = ($urandom_range(0, 19) != 0);
            read_valid   = ($urandom_range(0, 9) != 0);
            wr_rst       = ($urandom_range(0, 199) == 0);
            rd_rst       = ($urandom_range(0, 199) == 0);
            wr_burst_len = pick_len();
            rd_burst_len = pick_len();
            wr_fifo_num  = 16'($urandom_range(0, 300));
            rd_fifo_num  = 16'($urandom_range(600, 1024));
            sdram_wr_ack = ($urandom_range(0, 9) < 6);
            sdram_rd_ack = ($urandom_range(0, 9) < 6);
            model_edge();
            step();
            check("rnd.ctl", {busy, sdram_rd_req, sdram_wr_req}, {m_mode != 0, m_mode == 2, m_mode == 1});
            check("rnd.wr_addr", sdram_wr_addr, m_wptr);
            check("rnd.rd_addr", sdram_rd_addr, m_rptr);
            check("rnd.wr_burst", sdram_wr_burst, m_wlen);
            check("rnd.rd_burst", sdram_rd_burst, m_rlen);
            check("rnd.used", sdram_used, m_used);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_burst_sched.md
Name: sdram_burst_sched

Overview:
Schedules SDRAM bursts for the SDRAM-as-FIFO path: moves data from the SDRAM write FIFO into an SDRAM ring buffer, and from that ring buffer into the SDRAM read FIFO that the UART-side reader drains.
Arbitrates the single SDRAM controller port between write and read bursts.
Owns the ring-buffer write/read pointers and the occupancy count.
Sits between the FIFO level outputs and the SDRAM controller's write/read request ports.

Parameters:
ADDR_W, 24, SDRAM word address width
RING_BASE, 24'd0, first word address of the ring region
RING_SIZE, 24'd1024, ring size in words; must be a multiple of both burst lengths
RD_FIFO_DEPTH, 16'd1024, capacity of the SDRAM read FIFO in words

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous, active-low reset
init_end  in  1  SDRAM initialisation complete; no grants while low
read_valid  in  1  read path enabled by the upper layer
wr_rst  in  1  synchronous pulse: clear write pointer and occupancy
rd_rst  in  1  synchronous pulse: clear read pointer; occupancy set to 0
wr_burst_len  in  9  words per write burst, 1..256
rd_burst_len  in  9  words per read burst, 1..256
wr_fifo_num  in  16  words waiting in the SDRAM write FIFO
rd_fifo_num  in  16  words held in the SDRAM read FIFO
sdram_wr_ack  in  1  one pulse per accepted write beat
sdram_rd_ack  in  1  one pulse per returned read beat
sdram_wr_req  out  1  write burst request
sdram_wr_addr  out  ADDR_W  write burst start address
sdram_wr_burst  out  9  write burst length
sdram_rd_req  out  1  read burst request
sdram_rd_addr  out  ADDR_W  read burst start address
sdram_rd_burst  out  9  read burst length
busy  out  1  high in WRITE or READ
sdram_used  out  ADDR_W+1  words currently stored in the ring

Behaviour:
- Reset (async): state IDLE. All req = 0, busy = 0, sdram_used = 0. Both addresses = RING_BASE, burst outputs = 0. last_grant = READ, so write wins the first tie.
- States: IDLE, WRITE, READ.
- Write eligible when all hold: init_end, wr_burst_len != 0, wr_fifo_num >= wr_burst_len, sdram_used + wr_burst_len <= RING_SIZE.
- Read eligible when all hold: init_end, read_valid, rd_burst_len != 0, sdram_used >= rd_burst_len, rd_fifo_num + rd_burst_len <= RD_FIFO_DEPTH.
- IDLE evaluates eligibility every cycle.
  - Only one eligible: grant it.
  - Both eligible: grant the one opposite to last_grant (round-robin).
- On grant, at the same edge:
  - Enter WRITE or READ.
  - Latch the burst length into sdram_*_burst.
  - Assert the matching req.
  - busy = 1, last_grant updated.
- Latency: req rises 1 cycle after eligibility is true in IDLE.
- In WRITE/READ:
  - req stays high; addr/burst stay stable.
  - A 9-bit beat counter increments on each matching ack.
  - Burst end is the ack with beat_cnt == burst-1. At that edge: req = 0, busy = 0, counter cleared, return to IDLE.
- At burst end:
  - Pointer advances: next = addr + burst. If next >= RING_BASE + RING_SIZE, next = RING_BASE.
  - Write end: sdram_used += burst. Read end: sdram_used -= burst.
- Bursts are serialized, so sdram_used never sees a simultaneous +/- update.
- The IDLE cycle after each burst is mandatory, giving FIFO levels one cycle to settle. Back-to-back grants are therefore separated by at least one req-low cycle.
- Acks in IDLE, or acks of the non-granted type, are ignored.
- wr_rst / rd_rst:
  - Acted on only in IDLE. Arriving in WRITE/READ, the pulse is held pending and applied in the first IDLE cycle.
  - No grant is issued in the cycle a reset is applied.
  - wr_rst: write pointer = RING_BASE, sdram_used = 0, read pointer = RING_BASE.
  - rd_rst: read pointer = write pointer, sdram_used = 0.
  - Both pending together: wr_rst wins.
- Burst-length inputs are sampled only at grant; changes mid-burst have no effect.
- init_end falling mid-burst does not abort the burst; it only blocks new grants.
- Async reset mid-burst drops req immediately and discards pointer and occupancy state.

Test Plan:
1. Write then read: after reset with init_end = 1, wr_burst_len = rd_burst_len = 10 and wr_fifo_num = 10, a write is granted. After 10 wr_acks, used = 10, wr_addr = 10. With read_valid = 1 and rd_fifo_num = 0, a read is then granted at rd_addr = 0 (RING_BASE); after 10 rd_acks, used = 0.
2. Tie round-robin: used = 20, both eligible persistently, lens = 10. Grant order is W, R, W, R, with at least one req-low cycle between bursts.
3. Wrap-around: RING_SIZE = 1024, len = 256. Four writes give addresses 0, 256, 512, 768. The fourth leaves used = 1024 and wr_addr = 0; a fifth write is blocked until a read completes.
4. Read FIFO backpressure: rd_fifo_num = 1020, rd_burst_len = 10, used = 100 -> no read grant. Dropping rd_fifo_num to 1014 -> read granted next cycle.
5. wr_rst mid-burst: pulse at beat 3 of 10. The burst completes normally; in the following IDLE, pointers = 0, used = 0, and no grant is issued that cycle.
6. Async reset at beat 5 of 10: req drops immediately; all outputs read their reset values; later acks are ignored.
